// File: rtl/ex_stage_muldiv.sv
// Execute stage with a single-cycle ALU and branch unit, plus an iterative
// multiplier (shift-add) and divider (restoring) that each take one bit per
// cycle. Operands are forwarded and captured on accept, so an in-flight
// MUL/DIV ignores later input changes.
module ex_stage_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] mem_wb_data,
  input  logic            alu_src,
  input  logic [1:0]      op_class,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_e,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] read_data2_m,
  output logic [4:0]      rd_m,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            busy
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  work_hi, work_lo, mag_b_r, b2_r;
  logic [4:0]       rd_r;
  logic             neg_res, neg_rem, sel_alt;

  // Two's complement negate when n is set, XLEN and 2*XLEN wide variants.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_val, mag_a, mag_b, div_special;
  logic signed [XLEN-1:0] sa, sb, sfb;
  logic a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, br_taken;

  assign in_ready = (state == IDLE);

  // Operand forwarding, ALU, branch compare and MUL/DIV setup for the accept cycle.
  always_comb begin
    case (forward_a)
      2'b10:   op_a = ex_mem_alu_result;
      2'b01:   op_a = mem_wb_data;
      default: op_a = read_data1;
    endcase
    case (forward_b)
      2'b10:   fwd_b = ex_mem_alu_result;
      2'b01:   fwd_b = mem_wb_data;
      default: fwd_b = read_data2;
    endcase
    op_b = alu_src ? imm_ext : fwd_b;
    sa   = op_a;
    sb   = op_b;
    sfb  = fwd_b;

    case (alu_op)
      4'd0:    alu_val = op_a + op_b;
      4'd1:    alu_val = op_a - op_b;
      4'd2:    alu_val = op_a & op_b;
      4'd3:    alu_val = op_a | op_b;
      4'd4:    alu_val = op_a ^ op_b;
      4'd5:    alu_val = op_a << op_b[SH_W-1:0];
      4'd6:    alu_val = op_a >> op_b[SH_W-1:0];
      4'd7:    alu_val = sa >>> op_b[SH_W-1:0];
      4'd8:    alu_val = {{(XLEN-1){1'b0}}, sa < sb};
      4'd9:    alu_val = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_val = '0;
    endcase

    case (funct3)
      3'b000:  br_taken = (op_a == fwd_b);
      3'b001:  br_taken = (op_a != fwd_b);
      3'b100:  br_taken = (sa < sfb);
      3'b101:  br_taken = (sa >= sfb);
      3'b110:  br_taken = (op_a < fwd_b);
      3'b111:  br_taken = (op_a >= fwd_b);
      default: br_taken = 1'b0;
    endcase

    // MUL: 000/001 s*s, 010 s*u, 011 u*u. DIV: even funct3 signed.
    if (op_class == 2'b01) begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end else begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end
    a_neg = a_signed & op_a[XLEN-1];
    b_neg = b_signed & op_b[XLEN-1];
    mag_a = cond_neg(op_a, a_neg);
    mag_b = cond_neg(op_b, b_neg);

    div_zero    = (op_b == '0);
    div_ovf     = ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    div_special = funct3[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
  end

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nxt, mul_res;
  logic [XLEN-1:0]   div_r_nxt, div_q_nxt, mul_out, div_out;
  logic              div_ok, last_iter;

  // One iteration of shift-add multiply / restoring divide, and the final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b_r} : '0);
    mul_nxt   = {mul_sum, work_lo[XLEN-1:1]};
    mul_res   = cond_neg2(mul_nxt, neg_res);
    mul_out   = sel_alt ? mul_res[2*XLEN-1:XLEN] : mul_res[XLEN-1:0];
    div_sh    = {work_hi, work_lo[XLEN-1]};
    div_diff  = div_sh - {1'b0, mag_b_r};
    div_ok    = ~div_diff[XLEN];
    div_r_nxt = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    div_q_nxt = {work_lo[XLEN-2:0], div_ok};
    div_out   = sel_alt ? cond_neg(div_r_nxt, neg_rem) : cond_neg(div_q_nxt, neg_res);
    last_iter = (cnt == CNT_W'(XLEN - 1));
  end

  // Iteration datapath registers; loaded on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      work_hi <= '0;
      work_lo <= mag_a;
      mag_b_r <= mag_b;
      b2_r    <= fwd_b;
      rd_r    <= rd_e;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      sel_alt <= (op_class == 2'b01) ? (funct3[1:0] != 2'b00) : funct3[1];
    end else if (state == MUL) begin
      {work_hi, work_lo} <= mul_nxt;
    end else if (state == DIV) begin
      work_hi <= div_r_nxt;
      work_lo <= div_q_nxt;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      branch_taken  <= 1'b0;
      alu_result    <= '0;
      read_data2_m  <= '0;
      rd_m          <= '0;
      branch_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            if (op_class == 2'b01) begin
              state <= MUL;
              busy  <= 1'b1;
            end else if (op_class == 2'b10 && !(div_zero || div_ovf)) begin
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              state        <= DONE;
              out_valid    <= 1'b1;
              rd_m         <= rd_e;
              read_data2_m <= fwd_b;
              if (op_class == 2'b11) begin
                branch_taken  <= br_taken;
                branch_target <= pc + imm_ext;
                alu_result    <= pc + XLEN'(4);
              end else if (op_class == 2'b10) begin
                alu_result <= div_special;
              end else begin
                alu_result <= alu_val;
              end
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state        <= DONE;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
            alu_result   <= (state == MUL) ? mul_out : div_out;
            rd_m         <= rd_r;
            read_data2_m <= b2_r;
          end
        end
        default: begin
          state        <= IDLE;
          out_valid    <= 1'b0;
          branch_taken <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv (XLEN=32): ALU, MUL, DIV, branch and reset.
module tb_ex_stage_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc, read_data1, read_data2, imm_ext;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] ex_mem_alu_result, mem_wb_data;
  logic        alu_src;
  logic [1:0]  op_class;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic [4:0]  rd_e;
  logic        out_valid;
  logic [31:0] alu_result, read_data2_m, branch_target;
  logic [4:0]  rd_m;
  logic        branch_taken, busy;

  int checks = 0;
  int failures = 0;
  int lat, bcyc, rleak, ov_cnt;

  ex_stage_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .read_data1(read_data1), .read_data2(read_data2), .imm_ext(imm_ext),
    .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_data(mem_wb_data),
    .alu_src(alu_src), .op_class(op_class), .alu_op(alu_op), .funct3(funct3),
    .rd_e(rd_e), .out_valid(out_valid), .alu_result(alu_result),
    .read_data2_m(read_data2_m), .rd_m(rd_m), .branch_taken(branch_taken),
    .branch_target(branch_target), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one op (forwarding/pc set by caller), scrambles inputs after accept,
  // then waits (bounded) for out_valid. lat = accept-to-out_valid cycles.
  task automatic run_op(input logic [1:0] cls, input logic [3:0] aop, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic src,
                        input logic [31:0] im, input logic [4:0] rd);
    op_class = cls; alu_op = aop; funct3 = f3; read_data1 = a; read_data2 = b;
    alu_src = src; imm_ext = im; rd_e = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; read_data1 = 32'hDEADBEEF; read_data2 = 32'h5A5A5A5A;
    imm_ext = 32'h13579BDF; forward_a = 2'b00; forward_b = 2'b00;
    ex_mem_alu_result = 32'h0; mem_wb_data = 32'h0;
    lat = 1; bcyc = 0; rleak = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcyc++;
      if (in_ready) rleak++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc = '0; read_data1 = '0; read_data2 = '0;
    imm_ext = '0; forward_a = 2'b00; forward_b = 2'b00; ex_mem_alu_result = '0;
    mem_wb_data = '0; alu_src = 1'b0; op_class = 2'b00; alu_op = 4'd0;
    funct3 = 3'd0; rd_e = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_result", alu_result, 0);
    check("rst_branch_taken", branch_taken, 0);
    rst = 1'b0;

    // ADD rd1=5 imm=7, rs2 forwarded to read_data2_m
    run_op(2'b00, 4'd0, 3'd0, 32'd5, 32'h55, 1'b1, 32'd7, 5'd3);
    check("add_lat", lat, 1);
    check("add_result", alu_result, 12);
    check("add_rd_m", rd_m, 3);
    check("add_rd2_m", read_data2_m, 32'h55);
    check("done_not_ready", in_ready, 0);
    step();
    check("add_pulse_end", out_valid, 0);
    check("add_ready_again", in_ready, 1);
    check("add_hold", alu_result, 12);

    // SUB with MEM/WB-forwarded A: 100 - 30
    forward_a = 2'b01; mem_wb_data = 32'd100;
    run_op(2'b00, 4'd1, 3'd0, 32'd1, 32'd30, 1'b0, 32'd0, 5'd4);
    check("sub_result", alu_result, 70);
    step();
    run_op(2'b00, 4'd7, 3'd0, 32'h80000000, 32'd4, 1'b0, 32'd0, 5'd4);
    check("sra_result", alu_result, 32'hF8000000);
    step();
    run_op(2'b00, 4'd9, 3'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd4);
    check("sltu_result", alu_result, 1);
    step();
    run_op(2'b00, 4'd8, 3'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd4);
    check("slt_result", alu_result, 0);
    step();
    run_op(2'b00, 4'd5, 3'd0, 32'd3, 32'd33, 1'b0, 32'd0, 5'd4);
    check("sll_shamt_mask", alu_result, 6);
    step();

    // MULH with EX/MEM-forwarded A = 0x80000000, B = 2
    forward_a = 2'b10; ex_mem_alu_result = 32'h80000000;
    run_op(2'b01, 4'd0, 3'b001, 32'h00001234, 32'd2, 1'b0, 32'd0, 5'd9);
    check("mulh_lat", lat, 33);
    check("mulh_busy_cycles", bcyc, 32);
    check("mulh_ready_leak", rleak, 0);
    check("mulh_result", alu_result, 32'hFFFFFFFF);
    check("mulh_rd_m", rd_m, 9);
    check("mulh_busy_done", busy, 0);
    step();
    run_op(2'b01, 4'd0, 3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, 32'd0, 5'd9);
    check("mul_low", alu_result, 32'hFFFFFFEB);
    step();
    run_op(2'b01, 4'd0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd9);
    check("mulhu", alu_result, 32'hFFFFFFFE);
    step();
    run_op(2'b01, 4'd0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd9);
    check("mulhsu", alu_result, 32'hFFFFFFFF);
    step();

    // Division
    run_op(2'b10, 4'd0, 3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, 5'd10);
    check("div_lat", lat, 33);
    check("div_neg", alu_result, 32'hFFFFFFFD);
    step();
    run_op(2'b10, 4'd0, 3'b110, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, 5'd10);
    check("rem_neg", alu_result, 32'hFFFFFFFF);
    step();
    run_op(2'b10, 4'd0, 3'b101, 32'd7, 32'd0, 1'b0, 32'd0, 5'd10);
    check("divu_zero_lat", lat, 1);
    check("divu_zero", alu_result, 32'hFFFFFFFF);
    step();
    run_op(2'b10, 4'd0, 3'b111, 32'd7, 32'd0, 1'b0, 32'd0, 5'd10);
    check("remu_zero", alu_result, 7);
    step();
    run_op(2'b10, 4'd0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd10);
    check("div_ovf_lat", lat, 1);
    check("div_ovf", alu_result, 32'h80000000);
    step();
    run_op(2'b10, 4'd0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd10);
    check("rem_ovf", alu_result, 0);
    step();
    run_op(2'b10, 4'd0, 3'b101, 32'd100, 32'd7, 1'b0, 32'd0, 5'd10);
    check("divu", alu_result, 14);
    step();
    run_op(2'b10, 4'd0, 3'b111, 32'd100, 32'd7, 1'b0, 32'd0, 5'd10);
    check("remu", alu_result, 2);
    step();

    // Branches
    pc = 32'h100;
    run_op(2'b11, 4'd0, 3'b100, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h20, 5'd0);
    check("blt_lat", lat, 1);
    check("blt_taken", branch_taken, 1);
    check("blt_target", branch_target, 32'h120);
    check("blt_link", alu_result, 32'h104);
    step();
    check("taken_pulse_end", branch_taken, 0);
    check("target_hold", branch_target, 32'h120);
    run_op(2'b11, 4'd0, 3'b110, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h20, 5'd0);
    check("bltu_not_taken", branch_taken, 0);
    step();
    run_op(2'b11, 4'd0, 3'b000, 32'd42, 32'd42, 1'b0, 32'h40, 5'd0);
    check("beq_taken", branch_taken, 1);
    check("beq_target", branch_target, 32'h140);
    step();

    // Reset 10 cycles into a DIVU
    op_class = 2'b10; funct3 = 3'b101; read_data1 = 32'd100; read_data2 = 32'd7;
    alu_src = 1'b0; rd_e = 5'd11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_alu_result", alu_result, 0);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) ov_cnt++;
      step();
    end
    check("midrst_no_pulse", ov_cnt, 0);
    run_op(2'b00, 4'd0, 3'd0, 32'd5, 32'd0, 1'b1, 32'd7, 5'd12);
    check("post_rst_add_lat", lat, 1);
    check("post_rst_add", alu_result, 12);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
